// File: rtl/mem_pkg.sv
// Shared types and sizing for the data-memory store buffer.
package mem_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned MEM_AW   = 32;
    localparam int unsigned MEM_DW   = 32;

    // One posted store: word address (byte offset dropped) and data.
    typedef struct packed {
        logic [MEM_AW-3:0] wadr;
        logic [MEM_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-hit priority select over the store-buffer entries for load forwarding.
module sb_fwd_match
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  sb_entry_t          i_entries [DEPTH],
    input  logic [DEPTH-1:0]   i_valid,
    input  logic [PW-1:0]      i_tail,
    input  logic [MEM_AW-3:0]  i_wadr,
    output logic               o_hit,
    output logic [MEM_DW-1:0]  o_data
);

    // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); later hits override.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (i_valid[PW'(i_tail - PW'(k))] &&
                (i_entries[PW'(i_tail - PW'(k))].wadr == i_wadr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[PW'(i_tail - PW'(k))].data;
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write buffer between the MEM stage and data memory, with store-to-load forwarding.
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = MEM_AW,
    parameter int unsigned DW    = MEM_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_memwrite,
    input  logic                   cpu_memread,
    input  logic [AW-1:0]          cpu_adr,
    input  logic [DW-1:0]          cpu_wdata,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   stall,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_wadr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_radr,
    input  logic [DW-1:0]          mem_rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t        r_entries [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    logic [DW-1:0]    w_fwd_data;

    assign w_full = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = cpu_memwrite & ~w_full;
    assign w_pop  = ~empty & mem_ready;

    // A pop in the same cycle does not lift the stall; the retry lands next edge.
    assign stall     = cpu_memwrite & w_full;
    assign mem_we    = ~empty;
    assign mem_wadr  = {r_entries[r_head].wadr, 2'b00};
    assign mem_wdata = r_entries[r_head].data;
    assign mem_radr  = cpu_adr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_tail] <= '{wadr: cpu_adr[AW-1:2], data: cpu_wdata};
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .i_entries (r_entries),
        .i_valid   (r_valid),
        .i_tail    (r_tail),
        .i_wadr    (cpu_adr[AW-1:2]),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign cpu_rdata = (cpu_memread && w_hit) ? w_fwd_data : mem_rdata;

    a_no_load_store: assert property (@(posedge clk) disable iff (!reset)
                                      !(cpu_memwrite && cpu_memread));

endmodule

// File: tb/tb_mem_store_buffer.sv
// Randomized, model-checked bench for mem_store_buffer.
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_wadr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_radr;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_adr      (cpu_adr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .mem_we       (mem_we),
        .mem_wadr     (mem_wadr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_radr     (mem_radr),
        .mem_rdata    (mem_rdata),
        .empty        (empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t dlog[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   chk_en = 1'b0;
    bit   m_push;
    bit   m_pop;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Youngest queued store to the same word wins, otherwise memory data.
    function automatic logic [31:0] model_rdata(input logic [31:0] adr, input logic [31:0] mrd);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == {adr[31:2], 2'b00}) return mq[i].d;
        return mrd;
    endfunction

    // Reference queue: pop the oldest when memory accepts, push when not full.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() > 0) && mem_ready;
            m_push = cpu_memwrite && (mq.size() < DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{a: {cpu_adr[31:2], 2'b00}, d: cpu_wdata});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",    32'(count),  32'(mq.size()));
            chk("empty",    32'(empty),  32'(mq.size() == 0));
            chk("mem_we",   32'(mem_we), 32'(mq.size() != 0));
            chk("stall",    32'(stall),  32'(cpu_memwrite && (mq.size() == DEPTH)));
            chk("mem_radr", mem_radr,    cpu_adr);
            if (mq.size() > 0) begin
                chk("mem_wadr",  mem_wadr,  mq[0].a);
                chk("mem_wdata", mem_wdata, mq[0].d);
            end
            if (cpu_memread) chk("cpu_rdata", cpu_rdata, model_rdata(cpu_adr, mem_rdata));
            if (mem_we && mem_ready) dlog.push_back('{a: mem_wadr, d: mem_wdata});
        end
    end

    task automatic drv(input logic w, input logic r, input logic [31:0] adr,
                       input logic [31:0] wd, input logic rdy);
        cpu_memwrite = w;
        cpu_memread  = r;
        cpu_adr      = adr;
        cpu_wdata    = wd;
        mem_ready    = rdy;
        mem_rdata    = $urandom();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, 1'b0, $urandom(), $urandom(), 1'b1);
            nxt();
        end
    endtask

    // Called at posedge+1; reset low from +4 to +26, returns between edges.
    task automatic pulse_rst();
        #3 reset = 1'b0;
        #22 reset = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int n, input int a0, input int astep,
                           input int amod, input int d0);
        chk({nm, "_len"}, 32'(dlog.size()), 32'(n));
        for (int i = 0; i < n && i < dlog.size(); i++) begin
            chk({nm, "_adr"},  dlog[i].a, 32'(a0 + astep * (i % amod)));
            chk({nm, "_data"}, dlog[i].d, 32'(d0 + i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cyc;
        logic [31:0] rdv;
        int r;

        reset = 1'b1;
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        #21;
        chk("rst_empty",  32'(empty),  32'd1);
        chk("rst_count",  32'(count),  32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_stall",  32'(stall),  32'd0);
        reset = 1'b1;
        nxt();

        // Single store: visible one cycle later, retired the cycle after
        drv(1'b1, 1'b0, 32'd84, 32'd7, 1'b1);
        @(negedge clk); chk("st_empty_pre", 32'(empty), 32'd1);
        nxt();
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("st_mem_we",  32'(mem_we), 32'd1);
        chk("st_wadr",    mem_wadr,    32'd84);
        chk("st_wdata",   mem_wdata,   32'd7);
        nxt();
        @(negedge clk); chk("st_empty_post", 32'(empty), 32'd1);
        nxt();

        // Fill, stall on the fifth store, one-cycle drain, retry accepted
        dlog.delete();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b0, 32'(80 + 4 * i), 32'(100 + i), 1'b0);
            @(negedge clk);
            if (i == 4) begin
                chk("full_count", 32'(count), 32'd4);
                chk("full_stall", 32'(stall), 32'd1);
            end
            nxt();
        end
        drv(1'b1, 1'b0, 32'd96, 32'd104, 1'b1);
        @(negedge clk);
        chk("pp_full_stall", 32'(stall), 32'd1);
        chk("pp_full_count", 32'(count), 32'd4);
        nxt();
        drv(1'b1, 1'b0, 32'd96, 32'd104, 1'b0);
        @(negedge clk);
        chk("retry_count", 32'(count), 32'd3);
        chk("retry_stall", 32'(stall), 32'd0);
        nxt();
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk); chk("refill_count", 32'(count), 32'd4);
        nxt();
        idle_drain(6);
        chk_log("order", 5, 80, 4, 5, 100);

        // Forwarding: youngest of two stores to the same word; byte offset ignored
        drv(1'b1, 1'b0, 32'd80, 32'd5, 1'b0); nxt();
        drv(1'b1, 1'b0, 32'd80, 32'd7, 1'b0); nxt();
        drv(1'b0, 1'b1, 32'd80, 32'd0, 1'b0);
        @(negedge clk); chk("fwd_young", cpu_rdata, 32'd7);
        nxt();
        drv(1'b0, 1'b1, 32'd82, 32'd0, 1'b0);
        @(negedge clk); chk("fwd_offset", cpu_rdata, 32'd7);
        nxt();
        drv(1'b0, 1'b1, 32'd84, 32'd0, 1'b0);
        rdv = mem_rdata;
        @(negedge clk); chk("fwd_miss", cpu_rdata, rdv);
        nxt();
        drv(1'b0, 1'b1, 32'd80, 32'd0, 1'b1);
        @(negedge clk); chk("fwd_popping", cpu_rdata, 32'd7);
        nxt();
        idle_drain(3);

        // Push and pop together at count 1
        drv(1'b1, 1'b0, 32'd200, 32'd11, 1'b0); nxt();
        drv(1'b1, 1'b0, 32'd204, 32'd12, 1'b1);
        @(negedge clk); chk("pp1_count_pre", 32'(count), 32'd1);
        nxt();
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("pp1_count", 32'(count), 32'd1);
        chk("pp1_empty", 32'(empty), 32'd0);
        chk("pp1_wadr",  mem_wadr,   32'd204);
        chk("pp1_wdata", mem_wdata,  32'd12);
        nxt();
        idle_drain(2);

        // Reset while stores are pending discards them
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, 32'(300 + 4 * i), 32'(i), 1'b0);
            nxt();
        end
        drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        nxt();
        pulse_rst();
        @(negedge clk);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_count",  32'(count),  32'd0);
        nxt();

        // Wrap-around with toggling mem_ready; stalled stores are retried
        dlog.delete();
        acc = 0;
        cyc = 0;
        while (acc < 10 && cyc < 100) begin
            drv(1'b1, 1'b0, 32'(256 + 4 * (acc % 3)), 32'(1000 + acc), 1'((cyc % 2) == 0));
            @(negedge clk);
            if (!stall) acc++;
            nxt();
            cyc++;
        end
        chk("wrap_accepted", 32'(acc), 32'd10);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 32'(256 + 4 * i), 32'd0, 1'b0);
            nxt();
        end
        idle_drain(8);
        chk_log("wrap", 10, 256, 4, 3, 1000);

        // Random traffic over a small address window, with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 9));
            drv(1'(r < 4), 1'(r >= 4 && r < 7),
                32'(32'h40 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3)),
                $urandom(), 1'($urandom_range(0, 1)));
            if (n == 700) begin
                pulse_rst();
            end
            nxt();
        end
        idle_drain(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
